// File: rtl/simple_uart.sv
// 8N1 UART, bit period div+2 clocks; TX start bit appears the cycle after a write is accepted, RX byte is valid right after the stop bit.
// A write stalls combinationally (reg_dat_wait) while the transmitter is in INIT or SEND; an unread RX byte is overwritten.
module simple_uart (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  localparam logic [1:0] TX_INIT = 2'd0, TX_IDLE = 2'd1, TX_SEND = 2'd2;
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;

  logic [31:0] div_q, div_d;
  logic [32:0] bit_last, half_per, half_last;

  logic [1:0]  tx_state_q, tx_state_d;
  logic [32:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [8:0]  tx_shift_q, tx_shift_d;
  logic        ser_tx_q, ser_tx_d;

  logic        rx_meta_q, rx_sync_q;
  logic [1:0]  rx_state_q, rx_state_d;
  logic [32:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_dat_q, rx_dat_d;
  logic        rx_vld_q, rx_vld_d;

  logic        dat_di_unused;

  // 33-bit arithmetic so div = 2^32-1 still yields a correct period.
  assign bit_last  = {1'b0, div_q} + 33'd1;
  assign half_per  = ({1'b0, div_q} + 33'd2) >> 1;
  assign half_last = half_per - 33'd1;

  assign reg_div_do    = div_q;
  assign ser_tx        = ser_tx_q;
  assign reg_dat_wait  = reg_dat_we && (tx_state_q != TX_IDLE);
  assign reg_dat_do    = rx_vld_q ? {24'd0, rx_dat_q} : 32'hFFFF_FFFF;
  assign dat_di_unused = ^reg_dat_di[31:8];

  always_comb begin
    div_d = div_q;
    for (int i = 0; i < 4; i++) begin
      if (reg_div_we[i]) div_d[8*i +: 8] = reg_div_di[8*i +: 8];
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 33'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    ser_tx_d   = ser_tx_q;
    case (tx_state_q)
      TX_INIT: begin
        ser_tx_d = 1'b1;
        if (tx_cnt_q >= bit_last) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd14) begin
            tx_state_d = TX_IDLE;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (reg_dat_we) begin
          tx_state_d = TX_SEND;
          tx_shift_d = {1'b1, reg_dat_di[7:0]};
          tx_bit_d   = '0;
          ser_tx_d   = 1'b0;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q >= bit_last) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_bit_d   = '0;
            ser_tx_d   = 1'b1;
          end else begin
            ser_tx_d   = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end
      end
      default: begin
        tx_state_d = TX_INIT;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        ser_tx_d   = 1'b1;
      end
    endcase
    // A divider write aborts whatever the transmitter was doing.
    if (|reg_div_we) begin
      tx_state_d = TX_INIT;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      ser_tx_d   = 1'b1;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 33'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_dat_d   = rx_dat_q;
    rx_vld_d   = rx_vld_q && !reg_dat_re;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q >= half_last) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q >= bit_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      default: begin
        if (rx_cnt_q >= bit_last) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_dat_d   = rx_shift_q;
          rx_vld_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q      <= 32'd1;
      tx_state_q <= TX_INIT;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      ser_tx_q   <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_dat_q   <= '0;
      rx_vld_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      ser_tx_q   <= ser_tx_d;
      rx_meta_q  <= ser_rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_dat_q   <= rx_dat_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

endmodule

// File: tb/tb_simple_uart.sv
// Scoreboard bench for simple_uart: TX frames decoded mid-bit, RX frames driven serially.
module tb_simple_uart;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ser_tx;
  logic        ser_rx;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  always #5 clk = ~clk;

  simple_uart dut (
    .clk          (clk),
    .resetn       (resetn),
    .ser_tx       (ser_tx),
    .ser_rx       (ser_rx),
    .reg_div_we   (reg_div_we),
    .reg_div_di   (reg_div_di),
    .reg_div_do   (reg_div_do),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_do   (reg_dat_do),
    .reg_dat_wait (reg_dat_wait)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_byte(input logic [7:0] b, input int per);
    logic [9:0] frame;
    logic [7:0] want;
    tx_exp_q.push_back(b);
    reg_dat_di = {24'hABCDEF, b};
    reg_dat_we = 1'b1;
    step(1);
    reg_dat_we = 1'b0;
    step(per / 2);
    for (int i = 0; i < 10; i++) begin
      frame[i] = ser_tx;
      if (i < 9) step(per);
    end
    want = tx_exp_q.pop_front();
    check("tx_start", {31'd0, frame[0]}, 32'd0);
    check("tx_stop", {31'd0, frame[9]}, 32'd1);
    check("tx_byte", {24'd0, frame[8:1]}, {24'd0, want});
    step(per);
  endtask

  task automatic send_rx(input logic [7:0] b, input int per);
    rx_exp_q.push_back(b);
    ser_rx = 1'b0;
    step(per);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      step(per);
    end
    ser_rx = 1'b1;
    step(per);
  endtask

  // The newest pushed byte is the one the buffer must hold.
  task automatic rx_expect(input string tag);
    int t;
    logic [7:0] want;
    t = 0;
    while (reg_dat_do === 32'hFFFF_FFFF && t < 200) begin
      step(1);
      t++;
    end
    want = (rx_exp_q.size() > 0) ? rx_exp_q[$] : 8'h00;
    rx_exp_q.delete();
    check(tag, reg_dat_do, {24'd0, want});
  endtask

  task automatic rx_clear();
    reg_dat_re = 1'b1;
    step(1);
    reg_dat_re = 1'b0;
    check("rx_cleared", reg_dat_do, 32'hFFFF_FFFF);
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] want;
    logic [9:0] pat;
    int bad;
    pat        = 10'b1000100110;
    resetn     = 1'b0;
    ser_rx     = 1'b1;
    reg_div_we = 4'h0;
    reg_div_di = 32'h0;
    reg_dat_we = 1'b0;
    reg_dat_re = 1'b0;
    reg_dat_di = 32'h0;
    step(3);
    check("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
    check("rst_div", reg_div_do, 32'h1);
    check("rst_dat", reg_dat_do, 32'hFFFF_FFFF);

    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 44; i++) begin
      step(1);
      if (ser_tx !== 1'b1) bad++;
    end
    reg_dat_we = 1'b1;
    #1 check("init_wait_end", {31'd0, reg_dat_wait}, 32'd1);
    step(1);
    check("idle_after_45", {31'd0, reg_dat_wait}, 32'd0);
    reg_dat_we = 1'b0;
    check("init_tx_high", bad, 0);

    reg_div_di = 32'h30;
    reg_div_we = 4'hF;
    step(1);
    reg_div_we = 4'h0;
    check("div_30", reg_div_do, 32'h30);
    step(1);
    reg_dat_di = 32'h13;
    reg_dat_we = 1'b1;
    #1 check("wait_in_init", {31'd0, reg_dat_wait}, 32'd1);
    step(748);
    check("wait_init_749", {31'd0, reg_dat_wait}, 32'd1);
    step(1);
    check("wait_init_750", {31'd0, reg_dat_wait}, 32'd0);
    tx_exp_q.push_back(8'h13);
    step(1);
    check("wait_held", {31'd0, reg_dat_wait}, 32'd1);
    step(25);
    for (int i = 0; i < 10; i++) begin
      frame[i] = ser_tx;
      check($sformatf("tx13_bit%0d", i), {31'd0, frame[i]}, {31'd0, pat[i]});
      if (i < 9) step(50);
    end
    want = tx_exp_q.pop_front();
    check("tx13_byte", {24'd0, frame[8:1]}, {24'd0, want});
    step(24);
    check("wait_frame_end", {31'd0, reg_dat_wait}, 32'd1);
    step(1);
    check("wait_drop_500", {31'd0, reg_dat_wait}, 32'd0);
    reg_dat_we = 1'b0;

    send_rx(8'hA5, 50);
    rx_expect("rx_a5");
    rx_clear();
    send_rx(8'h3C, 50);
    send_rx(8'h81, 50);
    rx_expect("rx_overwrite");
    rx_clear();
    ser_rx = 1'b0;
    step(10);
    ser_rx = 1'b1;
    step(600);
    check("rx_glitch", reg_dat_do, 32'hFFFF_FFFF);
    send_rx(8'h5A, 50);
    rx_expect("rx_after_glitch");
    rx_clear();

    reg_dat_di = 32'h55;
    reg_dat_we = 1'b1;
    step(1);
    reg_dat_we = 1'b0;
    step(100);
    check("tx_midframe", {31'd0, ser_tx}, 32'd0);
    reg_div_di = 32'h8;
    reg_div_we = 4'hF;
    step(1);
    reg_div_we = 4'h0;
    check("abort_div", reg_div_do, 32'h8);
    check("abort_tx_high", {31'd0, ser_tx}, 32'd1);
    reg_div_di = 32'h0077_0000;
    reg_div_we = 4'b0100;
    step(1);
    check("div_lane2", reg_div_do, 32'h0077_0008);
    reg_div_di = 32'h0;
    step(1);
    reg_div_we = 4'h0;
    check("div_lane2_clr", reg_div_do, 32'h8);
    bad = 0;
    for (int i = 0; i < 148; i++) begin
      step(1);
      if (ser_tx !== 1'b1) bad++;
    end
    step(1);
    reg_dat_we = 1'b1;
    #1 check("reinit_wait", {31'd0, reg_dat_wait}, 32'd1);
    step(1);
    check("reinit_done", {31'd0, reg_dat_wait}, 32'd0);
    reg_dat_we = 1'b0;
    check("reinit_tx_high", bad, 0);
    tx_byte(8'hC6, 10);

    send_rx(8'h11, 10);
    rx_expect("rx_div8");
    reg_dat_di = 32'h0;
    reg_dat_we = 1'b1;
    step(1);
    reg_dat_we = 1'b0;
    step(25);
    check("tx_pre_reset", {31'd0, ser_tx}, 32'd0);
    resetn = 1'b0;
    step(1);
    check("midrst_tx", {31'd0, ser_tx}, 32'd1);
    check("midrst_div", reg_div_do, 32'h1);
    check("midrst_dat", reg_dat_do, 32'hFFFF_FFFF);
    resetn = 1'b1;
    step(44);
    reg_dat_we = 1'b1;
    #1 check("rst2_wait", {31'd0, reg_dat_wait}, 32'd1);
    step(1);
    check("rst2_idle", {31'd0, reg_dat_wait}, 32'd0);
    reg_dat_we = 1'b0;
    tx_byte(8'hE7, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simple_uart.md
SIMPLE_UART -- requirements
Module: simple_uart

Interface
REQ-001 clk  in  1  single system clock; all logic on rising edge.
REQ-002 resetn  in  1  synchronous, active-low reset.
REQ-003 ser_tx  out  1  serial transmit line, idle high.
REQ-004 ser_rx  in  1  serial receive line, idle high; unsynchronized external input.
REQ-005 reg_div_we  in  4  per-byte write enables for divider register (bit n -> bits 8n+7:8n).
REQ-006 reg_div_di  in  32  divider write data.
REQ-007 reg_div_do  out  32  current divider value.
REQ-008 reg_dat_we  in  1  transmit request; byte = reg_dat_di[7:0].
REQ-009 reg_dat_re  in  1  receive-data read strobe.
REQ-010 reg_dat_di  in  32  transmit data; bits 31:8 ignored.
REQ-011 reg_dat_do  out  32  received byte zero-extended, or 32'hFFFF_FFFF when no byte is buffered.
REQ-012 reg_dat_wait  out  1  combinational stall; high when reg_dat_we is high and the transmitter is busy.

Function
REQ-013 Bit period SHALL be (div + 2) clocks, div = divider register value.
REQ-014 Divider byte lanes SHALL update on the clock edge where the matching reg_div_we bit is high; reg_div_do SHALL show the new value the following cycle.
REQ-015 Any divider write SHALL (re)start the init sequence on the next clock, aborting any frame in progress.
REQ-016 Init sequence: ser_tx held high for 15 bit periods using the current divider; the transmitter counts as busy throughout.
REQ-017 Transmitter states: INIT, IDLE, SEND. INIT -> IDLE after 15 bit periods. IDLE -> SEND on a clock with reg_dat_we=1 and reg_dat_wait=0. SEND -> IDLE after 10 bit periods.
REQ-018 reg_dat_wait SHALL equal reg_dat_we AND (state != IDLE).
REQ-019 A write is accepted on the clock edge where reg_dat_we=1 and reg_dat_wait=0; the data byte is latched then, and the start bit begins on ser_tx the next cycle.
REQ-020 Frame format, LSB first: start bit 0, data bits 0..7, stop bit 1; each bit lasts exactly one bit period; no parity.
REQ-021 If reg_dat_we is held high after acceptance, reg_dat_wait SHALL be high for the whole frame. It SHALL drop when the frame completes, and the held request is then accepted as a new byte.
REQ-022 Receiver: idle until ser_rx is low; verify it is still low half a bit period later, else return to idle. Then sample 8 data bits at successive bit-period intervals (bit centres), LSB first, and wait one further bit period for the stop bit. The stop-bit level is not checked.
REQ-023 On frame completion, the received byte SHALL be stored and flagged valid. A new byte SHALL overwrite an unread one.
REQ-024 reg_dat_re high on a clock edge SHALL clear the valid flag; reg_dat_do SHALL return 32'hFFFF_FFFF from the next cycle until the next byte arrives.
REQ-025 Transmitter and receiver SHALL operate independently and concurrently; reg_dat_re and reg_dat_we in the same cycle are both honoured.
REQ-026 Counters SHALL be wide enough for div up to 2^32-1 without wrap; per-bit counters compare against the full 32-bit div.

Reset
REQ-027 While resetn=0 at a clock edge: div=1, reg_div_do=32'h0000_0001, ser_tx=1, receive buffer invalid (reg_dat_do=32'hFFFF_FFFF), receiver idle, transmitter enters INIT.
REQ-028 After reset release, INIT SHALL last 15*(1+2)=45 clocks with ser_tx=1, then reach IDLE.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately and force ser_tx high.

Verification
REQ-030 Reset release, no stimulus -> ser_tx stays 1; reg_div_do=32'h1; IDLE after 45 clocks (reg_dat_we probe: wait low).
REQ-031 Write div=32'h30 with reg_div_we=4'hF for 1 clock -> reg_div_do=32'h30 next cycle; INIT runs 750 clocks; a reg_dat_we during INIT sees wait=1.
REQ-032 After INIT, hold reg_dat_we=1 with data 32'h13 -> wait=1 one clock later; ser_tx sampled mid-bit every 50 clocks = 0,1,1,0,0,1,0,0,0,1; wait=0 after 500 clocks.
REQ-033 Drive ser_rx with frame 0xA5 at div+2 clocks/bit -> reg_dat_do=32'h0000_00A5 after stop bit; pulse reg_dat_re -> 32'hFFFF_FFFF.
REQ-034 ser_rx low glitch shorter than half a bit -> no byte received.
REQ-035 Divider write mid-frame -> frame aborted, ser_tx=1, 15-bit INIT restarts with the new divider.
